// File: rtl/uart_rx.sv
// Oversampled UART receiver: start/data/stop framing, LSB first, 16 ticks per bit.
// o_rx_done and o_rx update one clock after the final stop tick; no backpressure, so the consumer must take each word on o_rx_done.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic            o_rx_done,
  output logic [DBIT-1:0] o_rx
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  // Widened beyond 4 bits when the stop period needs it (SB_TICK = 24 or 32).
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_LAST = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   s, s_nxt;
  logic [NW-1:0]   n, n_nxt;
  logic [DBIT-1:0] b, b_nxt;
  logic [DBIT-1:0] rx_nxt;
  logic            done_nxt;
  logic [DBIT:0]   shift_in;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      b         <= '0;
      o_rx      <= '0;
      o_rx_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      s         <= s_nxt;
      n         <= n_nxt;
      b         <= b_nxt;
      o_rx      <= rx_nxt;
      o_rx_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    n_nxt     = n;
    b_nxt     = b;
    rx_nxt    = o_rx;
    done_nxt  = 1'b0;
    shift_in  = {i_rx, b};

    case (state)
      // Start edge is taken on any clock so tick phase never delays the frame.
      IDLE: begin
        if (!i_rx) begin
          state_nxt = START;
          s_nxt     = '0;
        end
      end

      START: begin
        if (i_s_tick) begin
          if (s == S_MID) begin
            if (!i_rx) begin
              state_nxt = DATA;
              s_nxt     = '0;
              n_nxt     = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end

      DATA: begin
        if (i_s_tick) begin
          if (s == S_LAST) begin
            s_nxt = '0;
            b_nxt = shift_in[DBIT:1];
            if (n == N_LAST) begin
              state_nxt = STOP;
            end else begin
              n_nxt = n + NW'(1);
            end
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end

      // Stop level is deliberately ignored; the frame completes on tick count alone.
      STOP: begin
        if (i_s_tick) begin
          if (s == S_STOP) begin
            state_nxt = IDLE;
            rx_nxt    = b;
            done_nxt  = 1'b1;
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: tick-aligned serial driver plus a frame-level scoreboard.
module tb_uart_rx;

  localparam int DBIT      = 8;
  // Ticks from driving the start bit low to the done pulse: half start bit, data bits, stop.
  localparam int FRAME_T16 = 8 + 16 * DBIT + 16;
  localparam int FRAME_T32 = 8 + 16 * DBIT + 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rx;
  logic            s_tick;
  logic            tick_en;
  logic            done;
  logic            done32;
  logic [DBIT-1:0] rx_dat;
  logic [DBIT-1:0] rx_dat32;

  always #5 clk = ~clk;

  uart_rx #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_rx      (rx),
    .i_s_tick  (s_tick),
    .o_rx_done (done),
    .o_rx      (rx_dat)
  );

  uart_rx #(.DBIT(DBIT), .SB_TICK(32)) dut32 (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_rx      (rx),
    .i_s_tick  (s_tick),
    .o_rx_done (done32),
    .o_rx      (rx_dat32)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [DBIT-1:0] dat;
    int              tick;
  } exp_t;

  exp_t exp_q[$];
  int   tick_cnt = 0;

  always @(posedge clk) if (s_tick) tick_cnt <= tick_cnt + 1;

  // One tick every 6 clocks while enabled.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (5) @(posedge clk);
      #1 s_tick = tick_en;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  logic            prev_done = 1'b0;
  logic [DBIT-1:0] prev_dat  = '0;
  int              stable_err = 0;
  int              done_cnt   = 0;
  int              last16_tick = -1;
  int              last32_tick = -1;
  logic [DBIT-1:0] last32_dat  = '0;
  exp_t            e;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      last16_tick = tick_cnt;
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rx_dat", {24'd0, rx_dat}, {24'd0, e.dat});
        chk("done_tick", tick_cnt, e.tick);
      end
    end else if (rst_n && rx_dat !== prev_dat) begin
      stable_err++;
    end
    prev_done = done;
    prev_dat  = rx_dat;
    if (done32) begin
      last32_tick = tick_cnt;
      last32_dat  = rx_dat32;
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (s_tick !== 1'b1);
    #1;
  endtask

  task automatic idle_ticks(input int k);
    repeat (k) wait_tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rx_dat", {24'd0, rx_dat}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_tick();
  endtask

  // Called tick-aligned and returns tick-aligned; abort_bit >= 0 resets mid data bit.
  task automatic send_frame(input logic [DBIT-1:0] d, input int abort_bit);
    int t0;
    t0 = tick_cnt;
    rx = 1'b0;
    if (abort_bit < 0) exp_q.push_back('{d, t0 + FRAME_T16});
    idle_ticks(16);
    for (int i = 0; i < DBIT; i++) begin
      rx = d[i];
      if (i == abort_bit) begin
        idle_ticks(6);
        pulse_reset();
        return;
      end
      idle_ticks(16);
    end
    rx = 1'b1;
    idle_ticks(16);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    chk("drain", exp_q.size(), 32'd0);
    wait_tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int              c0;
    int              t0;
    logic [DBIT-1:0] d;

    rst_n   = 1'b0;
    rx      = 1'b1;
    tick_en = 1'b1;
    #1;
    chk("reset_rx_dat", {24'd0, rx_dat}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_tick();
    idle_ticks(40);
    chk("quiet_after_reset", done_cnt, 32'd0);

    // Single frame, exact 9.5-bit latency checked by the scoreboard.
    send_frame(8'h55, -1);
    drain();
    chk("frame55_dat", {24'd0, rx_dat}, 32'h55);

    // Back-to-back with o_rx held through the second frame.
    c0 = done_cnt;
    send_frame(8'hA3, -1);
    fork
      send_frame(8'h0F, -1);
      begin
        idle_ticks(80);
        chk("hold_between", {24'd0, rx_dat}, 32'hA3);
      end
    join
    drain();
    chk("b2b_count", done_cnt - c0, 32'd2);
    chk("b2b_last", {24'd0, rx_dat}, 32'h0F);

    // Glitch on the start bit.
    c0 = done_cnt;
    rx = 1'b0;
    idle_ticks(4);
    rx = 1'b1;
    idle_ticks(200);
    chk("glitch_no_done", done_cnt - c0, 32'd0);
    chk("glitch_hold", {24'd0, rx_dat}, 32'h0F);

    // Reset during data bit 3 discards the frame.
    c0 = done_cnt;
    send_frame(8'h96, 3);
    idle_ticks(200);
    chk("abort_no_done", done_cnt - c0, 32'd0);
    chk("abort_rx_dat", {24'd0, rx_dat}, 32'd0);
    send_frame(8'hC8, -1);
    drain();
    chk("after_abort", {24'd0, rx_dat}, 32'hC8);

    // Tick stall mid-frame.
    d = DBIT'($urandom);
    fork
      send_frame(d, -1);
      begin
        idle_ticks(50);
        tick_en = 1'b0;
        repeat (200) @(posedge clk);
        #1 tick_en = 1'b1;
      end
    join
    drain();
    chk("stall_dat", {24'd0, rx_dat}, {24'd0, d});

    // Random frames with random idle gaps.
    for (int k = 0; k < 8; k++) begin
      d = DBIT'($urandom);
      send_frame(d, -1);
      idle_ticks($urandom_range(0, 5));
    end
    drain();

    // Longer stop period on the SB_TICK = 32 instance.
    pulse_reset();
    idle_ticks(4);
    t0 = tick_cnt;
    send_frame(8'hFF, -1);
    idle_ticks(40);
    drain();
    chk("sb32_tick", last32_tick - t0, FRAME_T32);
    chk("sb32_delta", last32_tick - last16_tick, 32'd16);
    chk("sb32_dat", {24'd0, last32_dat}, 32'hFF);

    chk("rx_dat_stable", stable_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8: number of data bits per frame, LSB first.
REQ-002 SHALL have parameter SB_TICK, default 16: number of oversampling ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL have port i_clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_rx, input, 1 bit: serial line; idle high, start bit low.
REQ-006 SHALL have port i_s_tick, input, 1 bit: oversampling enable, one clock wide, 16 ticks per bit period.
REQ-007 SHALL have port o_rx_done, output, 1 bit: one-clock pulse marking a completed frame.
REQ-008 SHALL have port o_rx, output, DBIT bits: last completely received data word.

Function
REQ-009 SHALL be a Moore FSM with states IDLE, START, DATA, STOP, a 4-bit tick counter s, a log2(DBIT)-bit bit counter n and a DBIT-bit shift register b.
REQ-010 In IDLE, i_rx = 0 sampled on any clock SHALL move to START with s = 0; no tick is required for this transition.
REQ-011 In START, on each i_s_tick: if s = 7 and i_rx = 0, go to DATA with s = 0, n = 0; if s = 7 and i_rx = 1, return to IDLE (false start, no output change); otherwise increment s.
REQ-012 In DATA, on each i_s_tick: if s = 15, set s = 0, shift b right inserting i_rx at the MSB (b <= {i_rx, b[DBIT-1:1]}), then go to STOP if n = DBIT-1, else increment n; otherwise increment s.
REQ-013 In STOP, on each i_s_tick: if s = SB_TICK-1, return to IDLE, load o_rx <= b and assert o_rx_done; otherwise increment s.
REQ-014 o_rx_done SHALL be registered, high for exactly one i_clk cycle per frame: the cycle after the final stop tick edge.
REQ-015 The stop-bit level SHALL NOT be checked; a frame completes regardless of i_rx during STOP.
REQ-016 o_rx SHALL change only when o_rx_done asserts; it SHALL hold its value during the reception of the next frame.
REQ-017 Clock edges without i_s_tick SHALL leave s, n, b and the state unchanged, except the IDLE->START transition in REQ-010.
REQ-018 In IDLE the next frame SHALL be accepted immediately, so back-to-back frames with a one-bit stop SHALL be received without loss.
REQ-019 The module SHALL be free of latches and combinational paths from i_rx to any output.

Reset
REQ-020 i_reset = 0 SHALL immediately force state IDLE and s = 0, n = 0, b = 0, o_rx = 0 and o_rx_done = 0, independent of i_clk.
REQ-021 A reset asserted mid-frame SHALL discard the partial frame; after release the module SHALL wait in IDLE for a new falling edge of i_rx.
REQ-022 After reset release, no o_rx_done SHALL occur until a full valid frame has been received.

Verification
REQ-023 The bench uses i_s_tick every 6 clocks (bit = 96 clocks) and sends 0x55 with 1 stop bit -> exactly one o_rx_done pulse about 9.5 bit times after the start edge, with o_rx = 0x55.
REQ-024 Back-to-back frames 0xA3 then 0x0F -> two single-cycle o_rx_done pulses; o_rx = 0xA3, then 0x0F; o_rx stays 0xA3 between the pulses.
REQ-025 i_rx low for 4 ticks, then high (glitch) -> FSM returns to IDLE; no o_rx_done; o_rx unchanged.
REQ-026 i_reset pulsed low during data bit 3 of a frame -> outputs 0 immediately; no o_rx_done for that frame; a following frame 0xC8 is received correctly.
REQ-027 i_s_tick held low mid-frame for 200 clocks -> the frame is neither advanced nor corrupted; with ticks resumed it completes with the correct byte.
REQ-028 SB_TICK = 32 and frame 0xFF -> o_rx_done appears 16 ticks later than with SB_TICK = 16; o_rx = 0xFF.
